// File: rtl/fpu_arbiter.sv
// Round-robin front end that time-shares one fixed-latency fpu among NREQ clients.
// One operation in flight: grant in IDLE, count FPU_LAT cycles in WAIT, hold the result in RESP.
module fpu_arbiter #(
    parameter int NREQ    = 4,
    parameter int FPU_LAT = 2,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*2-1:0]    req_op,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    output logic [1:0]           fpu_op,
    input  logic [31:0]          fpu_o,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 busy
);

    localparam int CW = (FPU_LAT < 2) ? 1 : $clog2(FPU_LAT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FPU_LAT - 1);
    localparam logic [IDW:0]   NREQ_C   = (IDW+1)'(NREQ);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     fpu_a_q, fpu_a_d;
    logic [31:0]     fpu_b_q, fpu_b_d;
    logic [1:0]      fpu_op_q, fpu_op_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [NREQ-1:0] win_oh;
    logic [31:0]     win_a, win_b;
    logic [1:0]      win_op;
    logic [IDW:0]    cand;
    logic [IDW:0]    rr_nxt;

    // Search starts at rr_q and wraps; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (IDW+1)'(k);
            if (cand >= NREQ_C) cand = cand - NREQ_C;
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_oh = '0;
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IDW'(k)) begin
                win_oh[k] = win_found;
                win_a     = req_a[32*k +: 32];
                win_b     = req_b[32*k +: 32];
                win_op    = req_op[2*k +: 2];
            end
        end
    end

    always_comb begin
        rr_nxt = {1'b0, win_idx} + (IDW+1)'(1);
        if (rr_nxt >= NREQ_C) rr_nxt = '0;
    end

    // Gated by rst_n so no client sees an accept while reset is asserted.
    assign req_ready = (state_q == IDLE && rst_n) ? win_oh : '0;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    fpu_a_d  = win_a;
                    fpu_b_d  = win_b;
                    fpu_op_d = win_op;
                    rsp_id_d = win_idx;
                    rr_d     = rr_nxt[IDW-1:0];
                    cnt_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d  = fpu_o;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a latency-2 fpu stand-in.
module tb_fpu_arbiter;
    localparam int NREQ = 4, FPU_LAT = 2, IDW = 2;

    logic                clk, rst_n;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [NREQ*32-1:0]  req_a, req_b;
    logic [NREQ*2-1:0]   req_op;
    logic [31:0]         fpu_a, fpu_b, fpu_o, rsp_data;
    logic [1:0]          fpu_op;
    logic                rsp_valid, rsp_ready, busy;
    logic [IDW-1:0]      rsp_id;

    int n_chk = 0, n_err = 0, cyc = 0;

    fpu_arbiter #(.NREQ(NREQ), .FPU_LAT(FPU_LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_o(fpu_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // fpu stand-in: known adds from the datasheet, otherwise a scrambling function.
    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        if (a == 32'h6DE4CBBE && b == 32'h70297696 && op == 2'd0) return 32'h70309CF4;
        if (a == 32'hEA1D2E96 && b == 32'h6F0CFD12 && op == 2'd0) return 32'h6F0CD5C6;
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
    endfunction

    // One register stage + combinational output = result valid FPU_LAT(2) edges after inputs.
    logic [65:0] stg_q;
    always @(posedge clk) stg_q <= {fpu_op, fpu_a, fpu_b};
    assign fpu_o = fmodel(stg_q[63:32], stg_q[31:0], stg_q[65:64]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[2*i +: 2]  = op;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Wait for a grant, check it goes to id, then follow the response.
    task automatic serve(input int id, output int acc);
        int t;
        logic [31:0] e;
        #1;
        t = 0;
        while (req_ready == '0 && t < 20) begin tick(); t++; end
        chk("grant", 32'(req_ready), 32'(1 << id));
        e = fmodel(req_a[32*id +: 32], req_b[32*id +: 32], req_op[2*id +: 2]);
        acc = cyc;
        tick();
        t = 0;
        while (!rsp_valid && t < 20) begin tick(); t++; end
        chk("rsp_lat", 32'(cyc - acc - 1), FPU_LAT);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_data", rsp_data, e);
    endtask

    initial begin
        int acc, prev;
        logic [31:0] e;
        bit bad;
        rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '1;
        req_a = '0; req_b = '0; req_op = '0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 32'h1111_1111 * (i + 1), 32'hA5A5_0000 + 32'(i), 2'(i));
        tick(); tick();

        // Reset state
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_data", rsp_data, 0);

        // 1: single request from requester 0
        req_valid = 4'b0001;
        set_req(0, 32'h6DE4CBBE, 32'h70297696, 2'd0);
        rst_n = 1'b1;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        chk("t1_ready_wait", 32'(req_ready), 0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_fpu_a", fpu_a, 32'h6DE4CBBE);
        chk("t1_fpu_b", fpu_b, 32'h70297696);
        req_valid = '0;
        tick();
        chk("t1_early", 32'(rsp_valid), 0);
        tick();
        chk("t1_valid", 32'(rsp_valid), 1);
        chk("t1_id", 32'(rsp_id), 0);
        chk("t1_data", rsp_data, 32'h70309CF4);
        rsp_ready = 1'b1;
        tick();
        chk("t1_idle", 32'(busy), 0);
        chk("t1_drop", 32'(rsp_valid), 0);

        // 2: all requesting, full rotation and throughput
        do_reset();
        req_valid = 4'b1111;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            serve(k % NREQ, acc);
            if (prev >= 0) chk("t2_gap", 32'(acc - prev), FPU_LAT + 2);
            prev = acc;
        end
        req_valid = '0;
        tick();

        // 3: rr_ptr moved to 2, then only 1 and 3 contend
        req_valid = 4'b0010;
        serve(1, acc);
        req_valid = 4'b1010;
        serve(3, acc);
        serve(1, acc);
        serve(3, acc);
        serve(1, acc);
        req_valid = '0;
        tick();

        // 4: response back-pressure
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        serve(0, acc);
        e = fmodel(req_a[31:0], req_b[31:0], req_op[1:0]);
        req_valid = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_valid", 32'(rsp_valid), 1);
            chk("t4_data", rsp_data, e);
            chk("t4_id", 32'(rsp_id), 0);
            chk("t4_busy", 32'(busy), 1);
            chk("t4_ready", 32'(req_ready), 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        chk("t4_idle", 32'(busy), 0);
        chk("t4_drop", 32'(rsp_valid), 0);

        // 5: requester 2 add
        set_req(2, 32'hEA1D2E96, 32'h6F0CFD12, 2'd0);
        req_valid = 4'b0100;
        serve(2, acc);
        chk("t5_data", rsp_data, 32'h6F0CD5C6);
        chk("t5_id", 32'(rsp_id), 2);
        req_valid = '0;
        tick();

        // 6: reset during WAIT
        req_valid = 4'b1000;
        #1;
        chk("t6_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tick();
        chk("t6_inwait", 32'(busy), 1);
        #2;
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_fpu_a", fpu_a, 0);
        chk("t6_fpu_b", fpu_b, 0);
        chk("t6_fpu_op", 32'(fpu_op), 0);
        chk("t6_id", 32'(rsp_id), 0);
        chk("t6_valid", 32'(rsp_valid), 0);
        chk("t6_ready", 32'(req_ready), 0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid) bad = 1'b1;
        end
        chk("t6_no_rsp", 32'(bad), 0);
        req_valid = 4'b1111;
        #1;
        chk("t6_first", 32'(req_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
